sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO. Successor to the dual-clock 16-bit/16-deep FIFO.
- Generalises data width and depth.
- Adds:
  - occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
  - selectable first-word-fall-through (FWFT) read mode
- Used where producer and consumer share one clock domain, so no gray-code pointer synchronisers are needed.

---
 rtl/sync_fifo_param.sv | 108 ++++++++++
 tb/tb_sync_fifo_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow, synchronous
// flush and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  FIFO_clk,
    input  logic                  FIFO_reset_n,
    input  logic                  FIFO_flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  FIFO_w_en,
    output logic                  FIFO_full,
    output logic                  FIFO_almost_full,
    input  logic                  FIFO_r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  FIFO_empty,
    output logic                  FIFO_almost_empty,
    output logic [ADDR_WIDTH:0]   FIFO_count,
    output logic                  FIFO_overflow,
    output logic                  FIFO_underflow
);

    localparam int                  DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    // Flags come only from the registered count, so no w_en/r_en -> flag path.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Accept decisions use current-cycle flags; flush discards both requests.
    assign w_wr = FIFO_w_en && !w_full  && !FIFO_flush;
    assign w_rd = FIFO_r_en && !w_empty && !FIFO_flush;

    assign FIFO_full         = w_full;
    assign FIFO_empty        = w_empty;
    assign FIFO_almost_full  = (r_count >= C_AF);
    assign FIFO_almost_empty = (r_count <= C_AE);
    assign FIFO_count        = r_count;
    assign FIFO_overflow     = r_ovf;
    assign FIFO_underflow    = r_udf;

    // Pointer, occupancy and sticky error state; flush behaves like a soft reset.
    always_ff @(posedge FIFO_clk or negedge FIFO_reset_n) begin
        if (!FIFO_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (FIFO_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + C_ONE;
            if (w_rd) r_rptr <= r_rptr + C_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (FIFO_w_en && w_full)  r_ovf <= 1'b1;
            if (FIFO_r_en && w_empty) r_udf <= 1'b1;
        end
    end

    // Storage array; left uninitialised on reset.
    always_ff @(posedge FIFO_clk) begin
        if (w_wr) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so reset reads 0.
            assign data_out = w_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            // Registered read port: loads on an accepted pop, holds otherwise.
            always_ff @(posedge FIFO_clk or negedge FIFO_reset_n) begin
                if (!FIFO_reset_n)  r_dout <= '0;
                else if (w_rd)      r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
            end
            assign data_out = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode and an FWFT-mode instance share
// one stimulus stream and are compared against a queue-based reference.
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
    logic          f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
    logic [AW:0]   s_count, f_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;
    logic [DW-1:0] m_dout = '0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(0)) u_std (
        .FIFO_clk(clk), .FIFO_reset_n(rst_n), .FIFO_flush(flush),
        .data_in(din), .FIFO_w_en(w_en), .FIFO_full(s_full),
        .FIFO_almost_full(s_af), .FIFO_r_en(r_en), .data_out(s_dout),
        .FIFO_empty(s_empty), .FIFO_almost_empty(s_ae), .FIFO_count(s_count),
        .FIFO_overflow(s_ovf), .FIFO_underflow(s_udf)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(1)) u_fw (
        .FIFO_clk(clk), .FIFO_reset_n(rst_n), .FIFO_flush(flush),
        .data_in(din), .FIFO_w_en(w_en), .FIFO_full(f_full),
        .FIFO_almost_full(f_af), .FIFO_r_en(r_en), .data_out(f_dout),
        .FIFO_empty(f_empty), .FIFO_almost_empty(f_ae), .FIFO_count(f_count),
        .FIFO_overflow(f_ovf), .FIFO_underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ":count"},     32'(s_count), 32'(n));
        chk({ctx, ":full"},      32'(s_full),  32'(n == DEPTH));
        chk({ctx, ":afull"},     32'(s_af),    32'(n >= AF));
        chk({ctx, ":empty"},     32'(s_empty), 32'(n == 0));
        chk({ctx, ":aempty"},    32'(s_ae),    32'(n <= AE));
        chk({ctx, ":ovf"},       32'(s_ovf),   32'(m_ovf));
        chk({ctx, ":udf"},       32'(s_udf),   32'(m_udf));
        chk({ctx, ":dout"},      32'(s_dout),  32'(m_dout));
        chk({ctx, ":fw_count"},  32'(f_count), 32'(n));
        chk({ctx, ":fw_empty"},  32'(f_empty), 32'(n == 0));
        chk({ctx, ":fw_full"},   32'(f_full),  32'(n == DEPTH));
        chk({ctx, ":fw_afull"},  32'(f_af),    32'(n >= AF));
        chk({ctx, ":fw_aempty"}, 32'(f_ae),    32'(n <= AE));
        chk({ctx, ":fw_ovf"},    32'(f_ovf),   32'(m_ovf));
        chk({ctx, ":fw_udf"},    32'(f_udf),   32'(m_udf));
        if (n != 0) chk({ctx, ":fw_dout"}, 32'(f_dout), 32'(q[0]));
    endtask

    // One clock of stimulus: drive, clock, advance the reference, check #1 later.
    task automatic step(input string ctx, input bit w, input bit r, input bit f,
                        input logic [DW-1:0] d);
        bit was_full, was_empty;
        w_en = w; r_en = r; flush = f; din = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (w && was_full)  m_ovf = 1;
            if (r && was_empty) m_udf = 1;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
        #1;
        check_all(ctx);
        w_en = 0; r_en = 0; flush = 0;
    endtask

    initial begin
        int wp;
        // Power-up reset
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x0001..0x0010, then one overflowing write
        for (int i = 1; i <= 16; i++) step("fill", 1, 0, 0, DW'(i));
        step("overflow", 1, 0, 0, 16'h00FF);

        // Drain in order, then one underflowing read (dout holds 0x0010)
        for (int i = 1; i <= 16; i++) step("drain", 0, 1, 0, '0);
        step("underflow", 0, 1, 0, '0);
        chk("underflow_hold", 32'(s_dout), 32'h10);

        // Clear sticky flags, park at count 5, then 20 simultaneous push/pop
        step("flush1", 0, 0, 1, '0);
        for (int i = 0; i < 5; i++) step("pre5", 1, 0, 0, 16'h0100 + DW'(i));
        for (int i = 0; i < 20; i++) step("rw_wrap", 1, 1, 0, DW'($urandom));
        for (int i = 0; i < 5; i++) step("drain5", 0, 1, 0, '0);

        // FWFT fall-through of a single word into an empty FIFO
        step("fwft_wr", 1, 0, 0, 16'hABCD);
        chk("fwft_abcd", 32'(f_dout), 32'hABCD);
        chk("fwft_nonempty", 32'(f_empty), 32'd0);
        step("fwft_rd", 0, 1, 0, '0);
        chk("fwft_empty", 32'(f_empty), 32'd1);

        // Count 9 with both sticky flags set, then flush with a write
        step("udf_set", 0, 1, 0, '0);
        for (int i = 0; i < 17; i++) step("fill2", 1, 0, 0, 16'h2000 + DW'(i));
        for (int i = 0; i < 7; i++) step("to9", 0, 1, 0, '0);
        chk("pre_flush_count", 32'(s_count), 32'd9);
        step("flush_w", 1, 0, 1, 16'hDEAD);
        chk("flush_count", 32'(s_count), 32'd0);

        // Randomised traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 59) == 0, DW'($urandom));
        end

        // Asynchronous reset mid-burst at count 7
        step("pre_rst_flush", 0, 0, 1, '0);
        for (int i = 0; i < 7; i++) step("burst7", 1, 0, 0, 16'h3000 + DW'(i));
        w_en = 1; din = 16'h3007;
        #2;
        rst_n = 1'b0;
        #1;
        w_en = 0;
        q.delete(); m_ovf = 0; m_udf = 0; m_dout = '0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_wr", 1, 0, 0, 16'h1234);
        step("post_rst_rd", 0, 1, 0, '0);
        chk("post_rst_data", 32'(s_dout), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
